instr_fetch: RTL

- Upstream fetch stage of the RV32I core: owns the PC, fetches from instruction memory over a req/ack handshake, and presents a stable 32-bit Instr to the control generator and decode.
- On retire it consumes the control generator's 3-bit Branch code, together with the ALU Zero/Less flags, imm and rs1 data, to compute the next PC.
- Multi-cycle fetch with a watchdog on memory latency.

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/npc_gen.sv | 37 +++
 rtl/instr_fetch.sv | 117 +++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: branch codes, NOP encoding, fetch states.
package rv32_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_RSVD = 3'b011;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_VALID,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/npc_gen.sv
// Next-PC generator: sequential, jal, jalr and conditional branch targets.
module npc_gen
    import rv32_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [2:0]  Branch,
    input  logic        Zero,
    input  logic        Less,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] pct;
    logic [31:0] jr;

    assign pc4 = PC + 32'd4;
    assign pct = PC + imm;
    assign jr  = rs1_data + imm;

    always_comb begin
        next_pc = pc4;
        case (Branch)
            BR_NONE: next_pc = pc4;
            BR_JAL:  next_pc = pct;
            BR_JALR: next_pc = jr & 32'hFFFF_FFFE;
            BR_RSVD: next_pc = pc4;
            BR_BEQ:  next_pc = Zero ? pct : pc4;
            BR_BNE:  next_pc = Zero ? pc4 : pct;
            BR_BLT:  next_pc = Less ? pct : pc4;
            BR_BGE:  next_pc = Less ? pc4 : pct;
            default: next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC owner, imem req/ack fetch with latency watchdog.
// Define MISALIGN_TRAP_EN to halt on misaligned next-PC instead of masking.
module instr_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    input  logic        retire,
    input  logic [2:0]  Branch,
    input  logic        Zero,
    input  logic        Less,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        fetch_err,
    output logic        misalign
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);

    fetch_state_t    state;
    logic [TO_W-1:0] wd;
    logic [31:0]     next_pc;
    logic            wd_expire;

    npc_gen u_npc (
        .PC       (PC),
        .Branch   (Branch),
        .Zero     (Zero),
        .Less     (Less),
        .imm      (imm),
        .rs1_data (rs1_data),
        .next_pc  (next_pc)
    );

    assign imem_addr = PC;
    assign wd_expire = WD_EN && (wd == WD_LAST);

`ifdef MISALIGN_TRAP_EN
    logic npc_bad;
    assign npc_bad = (next_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            PC          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            Instr       <= NOP_INSTR;
            fetch_err   <= 1'b0;
            wd          <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_REQ: begin
                    // req is low here only in the first cycle out of reset
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        Instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        wd          <= '0;
                        state       <= S_VALID;
                    end else if (wd_expire) begin
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        state     <= S_HALT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_VALID: begin
                    if (retire) begin
                        instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                        if (npc_bad) begin
                            misalign <= 1'b1;
                            state    <= S_HALT;
                        end else begin
                            PC       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= S_REQ;
                        end
`else
                        PC       <= next_pc & 32'hFFFF_FFFC;
                        imem_req <= 1'b1;
                        state    <= S_REQ;
`endif
                    end
                end
                S_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
